// File: rtl/add_sched_pkg.sv
// Shared types and default sizing for the add_sched shared-adder scheduler.
package add_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int NUM_REQ_DEF = 4;
    localparam int OP_W_DEF    = 3;

endpackage

// File: rtl/add_sched_rr_arbiter.sv
// Combinational round-robin winner search: starts at ptr_i, ascends, wraps.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         grant_o,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 any_o
);

    localparam int IDW = $clog2(N);

    int cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = 0;
        for (int i = 0; i < N; i++) begin
            cand = int'(ptr_i) + i;
            if (cand >= N) cand = cand - N;
            if (!any_o && req_i[cand]) begin
                any_o         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = IDW'(cand);
            end
        end
    end

endmodule

// File: rtl/add_sched.sv
// Round-robin scheduler sharing one adder among NUM_REQ requesters.
// One transaction in flight: IDLE (grant) -> EXEC (add) -> RESP (hold until taken).
module add_sched
    import add_sched_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int OP_W    = OP_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*OP_W-1:0]    req_x,
    input  logic [NUM_REQ*OP_W-1:0]    req_y,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [OP_W:0]              rsp_sum,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic                       busy,
    output logic [7:0]                 txn_cnt
);

    localparam int IDW = $clog2(NUM_REQ);

    state_t          state_q;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q;
    logic [OP_W-1:0] x_q, y_q, x_d, y_d;
    logic [OP_W:0]   sum_q, sum_d;
    logic            rsp_valid_q;
    logic [7:0]      cnt_q;

    logic [NUM_REQ-1:0] grant;
    logic [IDW-1:0]     win_idx;
    logic               win_any;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (win_idx),
        .any_o   (win_any)
    );

    always_comb begin
        x_d   = req_x[int'(win_idx)*OP_W +: OP_W];
        y_d   = req_y[int'(win_idx)*OP_W +: OP_W];
        ptr_d = (win_idx == IDW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        sum_d = {1'b0, x_q} + {1'b0, y_q};
    end

    // Grant is combinational so the requester sees acceptance in the same cycle.
    assign req_ready = (state_q == IDLE && win_any && !rst) ? grant : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            x_q         <= '0;
            y_q         <= '0;
            sum_q       <= '0;
            rsp_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (win_any) begin
                        x_q     <= x_d;
                        y_q     <= y_d;
                        id_q    <= win_idx;
                        ptr_q   <= ptr_d;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    sum_q       <= sum_d;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cnt_q       <= cnt_q + 8'd1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = sum_q;
    assign rsp_id    = id_q;
    assign busy      = (state_q != IDLE);
    assign txn_cnt   = cnt_q;

endmodule
